// File: rtl/layer_sequencer_if.sv
// Byte-stream and accelerator-side signals of the layer sequencer.
// The slave modport is the sequencer and the master modport is the stream source / accelerator.
interface layer_sequencer_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic [7:0] acc_data;
    logic       acc_load_r;
    logic       acc_load_wr;
    logic       acc_relu;
    logic       acc_sel;
    logic       acc_done;

    modport slave (
        input  s_valid, s_data, acc_done,
        output s_ready, acc_data, acc_load_r, acc_load_wr, acc_relu, acc_sel
    );

    modport master (
        output s_valid, s_data, acc_done,
        input  s_ready, acc_data, acc_load_r, acc_load_wr, acc_relu, acc_sel
    );
endinterface

// File: rtl/layer_sequencer.sv
// Layer sequencer: streams one image and per-kernel weights into an accelerator, then runs compute/activation per kernel.
// Optional COMPUTE watchdog is enabled by defining SCHED_TIMEOUT_EN.
module layer_sequencer #(
    parameter int IMG_BYTES   = 1024,
    parameter int W_BYTES     = 25,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         num_k,
    input  logic               relu_en,
    input  logic               prec_sel,
    layer_sequencer_if.slave   bus,
    output logic               busy,
    output logic               job_done,
    output logic               err,
    output logic [3:0]         k_idx
);

    // Byte counters are 11 bits wide, so phase lengths must fit them.
    if (IMG_BYTES < 1 || IMG_BYTES > 2048 || W_BYTES < 1 || W_BYTES > 2048 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("layer_sequencer: IMG_BYTES/W_BYTES must be 1..2048 and TIMEOUT_CYC >= 1");
    end

    localparam logic [10:0] IMG_LAST = 11'(IMG_BYTES - 1);
    localparam logic [10:0] W_LAST   = 11'(W_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_IMG, S_LOAD_W, S_COMPUTE, S_ACT, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t      r_state;
    logic [10:0] r_byte_cnt;
    logic [3:0]  r_num_k;
    logic        r_relu_en;
    logic        r_sel;
    logic [3:0]  r_k_idx;
    logic [7:0]  r_acc_data;
    logic        r_load_r;
    logic        r_load_wr;
    logic        r_relu;
    logic        r_s_ready;
    logic        r_busy;
    logic        r_job_done;

    logic        w_xfer;
    logic        w_last_k;

    assign w_xfer   = bus.s_valid && r_s_ready;
    assign w_last_k = (({1'b0, r_k_idx} + 5'd1) == {1'b0, r_num_k});

`ifdef SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= '0;
            r_num_k    <= '0;
            r_relu_en  <= 1'b0;
            r_sel      <= 1'b0;
            r_k_idx    <= '0;
            r_acc_data <= '0;
            r_load_r   <= 1'b0;
            r_load_wr  <= 1'b0;
            r_relu     <= 1'b0;
            r_s_ready  <= 1'b0;
            r_busy     <= 1'b0;
            r_job_done <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            r_to_cnt   <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_load_r   <= 1'b0;
            r_load_wr  <= 1'b0;
            r_relu     <= 1'b0;
            r_job_done <= 1'b0;

            // s_ready is only high in the load states, so the strobe type follows the state.
            if (w_xfer) begin
                r_acc_data <= bus.s_data;
                r_load_r   <= (r_state == S_LOAD_IMG);
                r_load_wr  <= (r_state == S_LOAD_W);
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num_k    <= num_k;
                        r_relu_en  <= relu_en;
                        r_sel      <= prec_sel;
                        r_k_idx    <= '0;
                        r_byte_cnt <= '0;
                        r_busy     <= 1'b1;
                        if (num_k != 4'd0) begin
                            r_state   <= S_LOAD_IMG;
                            r_s_ready <= 1'b1;
                        end else begin
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_LOAD_IMG: begin
                    if (w_xfer) begin
                        if (r_byte_cnt == IMG_LAST) begin
                            r_byte_cnt <= '0;
                            r_state    <= S_LOAD_W;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 11'd1;
                        end
                    end
                end
                S_LOAD_W: begin
                    if (w_xfer) begin
                        if (r_byte_cnt == W_LAST) begin
                            r_byte_cnt <= '0;
                            r_s_ready  <= 1'b0;
                            r_state    <= S_COMPUTE;
`ifdef SCHED_TIMEOUT_EN
                            r_to_cnt   <= '0;
`endif
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 11'd1;
                        end
                    end
                end
                S_COMPUTE: begin
                    // acc_done takes priority over an expiring watchdog in the same cycle.
                    if (bus.acc_done) begin
                        r_state <= r_relu_en ? S_ACT : S_NEXT;
                        r_relu  <= r_relu_en;
                    end
`ifdef SCHED_TIMEOUT_EN
                    else if (r_to_cnt == TO_LAST) begin
                        r_state <= S_ERR;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                S_ACT: begin
                    r_state <= S_NEXT;
                end
                S_NEXT: begin
                    if (w_last_k) begin
                        r_state <= S_DONE;
                    end else begin
                        r_k_idx    <= r_k_idx + 4'd1;
                        r_byte_cnt <= '0;
                        r_s_ready  <= 1'b1;
                        r_state    <= S_LOAD_W;
                    end
                end
                S_DONE: begin
                    r_job_done <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                S_ERR: begin
                    // Leaving ERR only clears it; the job itself needs a later start.
                    if (start) begin
                        r_state <= S_IDLE;
`ifdef SCHED_TIMEOUT_EN
                        r_err   <= 1'b0;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.s_ready     = r_s_ready;
    assign bus.acc_data    = r_acc_data;
    assign bus.acc_load_r  = r_load_r;
    assign bus.acc_load_wr = r_load_wr;
    assign bus.acc_relu    = r_relu;
    assign bus.acc_sel     = r_sel;
    assign busy            = r_busy;
    assign job_done        = r_job_done;
    assign k_idx           = r_k_idx;

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter IMG_BYTES, default 1024, image bytes per job.
REQ-002 Parameter W_BYTES, default 25, weight bytes per kernel.
REQ-003 Parameter TIMEOUT_CYC, default 4096, max COMPUTE cycles before error.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-006 start  in  1  job request; sampled only in IDLE or ERR.
REQ-007 num_k  in  4  kernels per job, latched on accepted start.
REQ-008 relu_en  in  1  activation enable, latched on accepted start.
REQ-009 prec_sel  in  1  precision select, latched on accepted start.
REQ-010 s_valid  in  1  byte-stream valid.
REQ-011 s_data  in  8  byte-stream data.
REQ-012 s_ready  out  1  byte-stream ready.
REQ-013 acc_data  out  8  registered byte to accelerator.
REQ-014 acc_load_r  out  1  image-byte strobe, aligned with acc_data.
REQ-015 acc_load_wr  out  1  weight-byte strobe, aligned with acc_data.
REQ-016 acc_relu  out  1  one-cycle activation pulse.
REQ-017 acc_sel  out  1  latched prec_sel, held for the whole job.
REQ-018 acc_done  in  1  accelerator compute-complete.
REQ-019 busy  out  1  high in every state except IDLE and ERR.
REQ-020 job_done  out  1  one-cycle pulse at job end.
REQ-021 err  out  1  high while in ERR.
REQ-022 k_idx  out  4  index of current kernel, 0-based.

Function
REQ-023 States: IDLE, LOAD_IMG, LOAD_W, COMPUTE, ACT, NEXT, DONE, ERR; one-hot or binary free.
REQ-024 Transfer occurs when s_valid and s_ready both high; s_ready is high only in LOAD_IMG and LOAD_W.
REQ-025 Each transfer registers s_data to acc_data and asserts the matching acc_load_* strobe for exactly one cycle, one cycle after the transfer.
REQ-026 IDLE: start with num_k != 0 -> LOAD_IMG, k_idx=0; start with num_k == 0 -> DONE, no strobes issued.
REQ-027 LOAD_IMG: count transfers; on transfer number IMG_BYTES -> LOAD_W.
REQ-028 LOAD_W: count transfers; on transfer number W_BYTES -> COMPUTE.
REQ-029 COMPUTE: wait for acc_done; acc_done high -> ACT if relu_en latched, else NEXT.
REQ-030 ACT: acc_relu high for one cycle, then NEXT.
REQ-031 NEXT: k_idx+1 == num_k -> DONE; otherwise k_idx increments and state -> LOAD_W; image is not reloaded.
REQ-032 DONE: job_done high for one cycle, then IDLE.
REQ-033 ERR: sticky; start high -> IDLE without starting a job; a new job needs a later start.
REQ-034 start is ignored while busy; acc_done is ignored outside COMPUTE; s_valid is ignored while s_ready is low.
REQ-035 Byte counters are 11 bits, clear on entry to each load state, and never wrap within a phase.
REQ-036 Stalls (s_valid low) hold the state and counters with no strobes issued.

Reset
REQ-037 While reset is low: state IDLE, all counters 0, k_idx 0, acc_data 0, every output 0 (s_ready, strobes, acc_relu, acc_sel, busy, job_done, err).
REQ-038 Reset mid-job aborts the job with no job_done pulse; strobes in flight are dropped.

Configuration
REQ-039 Macro SCHED_TIMEOUT_EN defined: a cycle counter clears on COMPUTE entry; reaching TIMEOUT_CYC without acc_done -> ERR. acc_done arriving in the same cycle as the limit wins (-> ACT/NEXT).
REQ-040 Macro SCHED_TIMEOUT_EN undefined: no watchdog logic; COMPUTE waits indefinitely; ERR is unreachable and err is tied 0.

Verification
REQ-041 num_k=2, relu_en=1, continuous s_valid, 1024+25+25 bytes, acc_done 10 cycles after each COMPUTE entry -> exactly 1024 acc_load_r, 50 acc_load_wr, 2 acc_relu pulses, 1 job_done pulse, k_idx 0 then 1.
REQ-042 s_valid toggling every other cycle during LOAD_IMG -> strobe count still 1024, state holds during gaps, data order preserved.
REQ-043 start with num_k=0 -> job_done 2 cycles later, s_ready never high, no strobes.
REQ-044 With SCHED_TIMEOUT_EN and TIMEOUT_CYC=16, acc_done withheld -> err high after 16 COMPUTE cycles; start -> IDLE, err low.
REQ-045 reset driven low during LOAD_W byte 10 -> all outputs 0 immediately; after release, a fresh start runs a full job correctly.
REQ-046 start pulsed during COMPUTE -> ignored; latched num_k, relu_en and acc_sel unchanged.
